c499_vector_applier: RTL and testbench
======================================

# c499_vector_applier

Sequential test-application stage that sits directly upstream of the c499 32-bit single-error-correcting combinational core. It accepts 41-bit test patterns and their expected 32-bit golden responses over a valid/ready stream, drives each pattern onto the core's inputs, and waits a programmable settle time. It then samples the core's 32 outputs, compares them to the golden value, and folds them into a MISR signature. The per-pattern verdicts and the end-of-session summary feed the evolutionary Trojan-detection fitness logic.

## Interface
- SETTLE_CYCLES, 1: clocks between driving a pattern and sampling `dut_out`; legal range 1..15.
- CNT_W, 16: width of the pattern index and mismatch counters.
- MISR_POLY, 32'h04C11DB7: MISR feedback polynomial.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- vec_valid  in  1  pattern stream valid.
- vec_ready  out  1  pattern stream ready.
- vec_data  in  41  pattern; bit 0 drives N1 … bit 40 drives N137, in c499 port order.
- vec_exp  in  32  golden response; bit 0 is N724 … bit 31 is N755.
- vec_last  in  1  marks the final pattern of a session.
- dut_in  out  41  registered drive to the c499 inputs.
- dut_out  in  32  c499 outputs.
- res_valid  out  1  per-pattern result valid.
- res_ready  in  1  result consumer ready.
- res_index  out  CNT_W  index of the pattern within its session, starting at 0.
- res_mismatch  out  1  1 when `dut_out` differed from `vec_exp`.
- res_diff  out  32  `dut_out ^ vec_exp`.
- done  out  1  session complete; held until the next accepted pattern or reset.
- sig  out  32  MISR signature of the session.
- err_count  out  CNT_W  number of mismatching patterns; saturates at all-ones.

## Operation
- States are IDLE, SETTLE, CAPTURE and REPORT.
- IDLE
  - `vec_ready` is 1.
  - On `vec_valid & vec_ready`: latch `vec_data` into `dut_in`, latch `vec_exp` and `vec_last`, and load the settle counter with SETTLE_CYCLES−1.
  - If `done` was 1, clear `done`, `sig`, `err_count` and the index first, so the accepted pattern starts a new session at index 0.
  - Next state is SETTLE.
- SETTLE: decrement the counter; go to CAPTURE when it reaches 0.
- CAPTURE (one cycle)
  - Sample `dut_out` into the result registers and compute `res_diff`.
  - Update the MISR: sig ← ({sig[30:0],1'b0} ^ (sig[31] ? MISR_POLY : 0)) ^ dut_out.
  - If there is a mismatch, increment `err_count` unless it is all-ones.
  - Next state is REPORT.
- REPORT
  - `res_valid` is 1. Result fields are stable until the handshake completes.
  - On `res_ready`:
    - Increment the index, wrapping modulo 2^CNT_W.
    - If the latched last flag is 1, set `done`.
    - Next state is IDLE.
- `vec_ready` is 0 in every state other than IDLE; only one pattern is in flight at a time.
- `dut_in` holds the last applied pattern until the next pattern is accepted.

## Timing
- Reset values: state IDLE, `dut_in` 0, `res_*` 0, `done` 0, `sig` 0, `err_count` 0, index 0.
- Handshake into IDLE at cycle t:
  - `dut_in` updates at t+1.
  - CAPTURE samples `dut_out` at t+1+SETTLE_CYCLES.
  - `res_valid` rises at t+2+SETTLE_CYCLES.
- Minimum pattern period is SETTLE_CYCLES+3 cycles when `res_ready` is held at 1.
- Back-pressure: `res_valid` stays high and all `res_*` fields stay frozen for as long as `res_ready` is 0.
- `sig` and `err_count` update in the cycle after CAPTURE. They are final once `done` rises, in the cycle after the last REPORT handshake.
- A `rst` pulse in any state aborts the pattern in flight with no partial result, and all outputs return to their reset values on the next edge.
- When the index wraps from all-ones to 0 mid-session, the session continues; no flag is raised.

## Structure
- Shared package `c499_tb_pkg`:
  - state enum.
  - C499_IN_W=41 and C499_OUT_W=32.
  - default MISR polynomial.
- Natural sub-module: `misr32`, holding the signature register with clear, enable and data ports. It is reused by the downstream fitness logic.
- The FSM and counters live in the top module.

## Test plan
- Pattern 0, behavioural stub returns 0, `vec_exp`=0, `vec_last`=1:
  - `res_mismatch`=0, `res_index`=0.
  - `sig`=0, `err_count`=0.
  - `done`=1 at cycle t+3+SETTLE_CYCLES.
- Stub returns 32'h00000001 and `vec_exp`=0:
  - `res_diff`=32'h00000001, `res_mismatch`=1, `err_count`=1.
  - `sig`=32'h00000001.
- SETTLE_CYCLES=4, with the stub output changing 2 cycles after `dut_in` changes: the captured value is the post-change value.
- Hold `res_ready`=0 for 10 cycles:
  - `res_valid` stays 1 and the fields are unchanged.
  - `vec_ready` stays 0.
  - A pattern offered meanwhile is accepted only after the handshake.
- Assert `rst` during SETTLE: outputs return to reset values, and the next pattern reports `res_index`=0.
- CNT_W=4 with 17 mismatching patterns: `err_count` saturates at 15 and `res_index` wraps to 0 on pattern 16.

Source files
------------

// File: rtl/c499_tb_pkg.sv
// Shared types and constants for the c499 vector applier and its fitness consumers.

package c499_tb_pkg;

    localparam int unsigned C499_IN_W  = 41;
    localparam int unsigned C499_OUT_W = 32;

    localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StReport
    } state_e;

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register with synchronous clear and enable.

module misr32
    import c499_tb_pkg::*;
#(
    parameter logic [31:0] POLY = MISR_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] sig
);

    logic [31:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c499_vector_applier.sv
// Applies one test pattern at a time to the c499 core, waits a settle time, then
// captures and compares its response and folds it into a session signature.

module c499_vector_applier
    import c499_tb_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16,
    parameter logic [31:0] MISR_POLY     = MISR_POLY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [C499_IN_W-1:0]  vec_data,
    input  logic [C499_OUT_W-1:0] vec_exp,
    input  logic                  vec_last,
    output logic [C499_IN_W-1:0]  dut_in,
    input  logic [C499_OUT_W-1:0] dut_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CNT_W-1:0]      res_index,
    output logic                  res_mismatch,
    output logic [C499_OUT_W-1:0] res_diff,
    output logic                  done,
    output logic [31:0]           sig,
    output logic [CNT_W-1:0]      err_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [C499_IN_W-1:0]    dut_in_q, dut_in_d;
    logic [C499_OUT_W-1:0]   exp_q, exp_d;
    logic                    last_q, last_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        err_q, err_d;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        res_index_q, res_index_d;
    logic [C499_OUT_W-1:0]   res_diff_q, res_diff_d;
    logic                    misr_clr, misr_en;

    always_comb begin
        state_d     = state_q;
        dut_in_d    = dut_in_q;
        exp_d       = exp_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        done_d      = done_q;
        res_index_d = res_index_q;
        res_diff_d  = res_diff_q;
        misr_clr    = 1'b0;
        misr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (vec_valid) begin
                    dut_in_d = vec_data;
                    exp_d    = vec_exp;
                    last_d   = vec_last;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = StSettle;
                    // First pattern after a finished session opens a fresh one.
                    if (done_q) begin
                        done_d   = 1'b0;
                        idx_d    = '0;
                        err_d    = '0;
                        misr_clr = 1'b1;
                    end
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                res_diff_d  = dut_out ^ exp_q;
                res_index_d = idx_q;
                misr_en     = 1'b1;
                if ((|res_diff_d) && (err_q != '1)) begin
                    err_d = err_q + CNT_W'(1);
                end
                state_d = StReport;
            end
            StReport: begin
                if (res_ready) begin
                    idx_d   = idx_q + CNT_W'(1);
                    done_d  = done_q | last_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dut_in_q    <= '0;
            exp_q       <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            err_q       <= '0;
            done_q      <= 1'b0;
            res_index_q <= '0;
            res_diff_q  <= '0;
        end else begin
            state_q     <= state_d;
            dut_in_q    <= dut_in_d;
            exp_q       <= exp_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            done_q      <= done_d;
            res_index_q <= res_index_d;
            res_diff_q  <= res_diff_d;
        end
    end

    misr32 #(
        .POLY (MISR_POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (misr_clr),
        .en   (misr_en),
        .data (dut_out),
        .sig  (sig)
    );

    assign vec_ready    = (state_q == StIdle);
    assign res_valid    = (state_q == StReport);
    assign dut_in       = dut_in_q;
    assign res_index    = res_index_q;
    assign res_diff     = res_diff_q;
    assign res_mismatch = |res_diff_q;
    assign done         = done_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_c499_vector_applier.sv
// Randomized bench for c499_vector_applier against a pattern-level session model,
// using a stub core whose response lags its inputs by two cycles.

module tb_c499_vector_applier;

    localparam int unsigned S    = 4;
    localparam int unsigned CW   = 4;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam int unsigned NRND = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        vec_valid, vec_ready, vec_last;
    logic [40:0] vec_data, dut_in;
    logic [31:0] vec_exp, dut_out, res_diff, sig;
    logic        res_valid, res_ready, res_mismatch, done;
    logic [CW-1:0] res_index, err_count;

    always #5 clk = ~clk;

    c499_vector_applier #(
        .SETTLE_CYCLES (S),
        .CNT_W         (CW),
        .MISR_POLY     (POLY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .vec_data     (vec_data),
        .vec_exp      (vec_exp),
        .vec_last     (vec_last),
        .dut_in       (dut_in),
        .dut_out      (dut_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_index    (res_index),
        .res_mismatch (res_mismatch),
        .res_diff     (res_diff),
        .done         (done),
        .sig          (sig),
        .err_count    (err_count)
    );

    // Stub core: response is a fixed function of its inputs, visible two cycles late.
    function automatic logic [31:0] stub_f(input logic [40:0] x);
        return x[31:0] ^ {x[40:32], 23'd0};
    endfunction

    logic [40:0] d1 = '0;
    logic [40:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= dut_in;
        d2 <= d1;
    end
    assign dut_out = stub_f(d2);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Session model
    logic [31:0] m_sig;
    int unsigned m_err, m_idx;
    bit          m_done;

    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] t;
        t = {s[30:0], 1'b0};
        if (s[31]) t = t ^ POLY;
        return t ^ d;
    endfunction

    function automatic logic [40:0] rand_pat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[40:0];
    endfunction

    task automatic model_reset();
        m_sig  = '0;
        m_err  = 0;
        m_idx  = 0;
        m_done = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dut_in"}, dut_in, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_index"}, res_index, 0);
        check({tag, "_res_diff"}, res_diff, 0);
        check({tag, "_res_mm"}, res_mismatch, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sig"}, sig, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_vec_ready"}, vec_ready, 1);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
    task automatic apply(input logic [40:0] data, input logic [31:0] exp, input bit last,
                         input int hold, input logic [40:0] offer);
        int          n;
        logic [31:0] resp, diff;
        bit          mm;
        if (m_done) model_reset();
        vec_data  = data;
        vec_exp   = exp;
        vec_last  = last;
        vec_valid = 1'b1;
        check("accept_ready", vec_ready, 1);
        @(negedge clk);
        vec_valid = 1'b0;
        check("dut_in", dut_in, data);
        check("busy", vec_ready, 0);
        check("sess_sig", sig, m_sig);
        check("sess_err", err_count, m_err);
        check("done_clr", done, 0);

        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, S + 1);

        resp = stub_f(data);
        diff = resp ^ exp;
        mm   = (diff != 0);
        m_sig = misr_next(m_sig, resp);
        if (mm && m_err < 15) m_err++;

        check("res_index", res_index, m_idx % 16);
        check("res_diff", res_diff, diff);
        check("res_mm", res_mismatch, mm);
        check("sig", sig, m_sig);
        check("err_count", err_count, m_err);
        check("rep_ready", vec_ready, 0);

        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                vec_data  = offer;
                vec_exp   = ~exp;
                vec_last  = 1'b0;
                vec_valid = 1'b1;
            end
            @(negedge clk);
            check("bp_valid", res_valid, 1);
            check("bp_diff", res_diff, diff);
            check("bp_index", res_index, m_idx % 16);
            check("bp_mm", res_mismatch, mm);
            check("bp_ready", vec_ready, 0);
            check("bp_dut_in", dut_in, data);
        end

        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        m_idx++;
        if (last) m_done = 1;
        check("rel_valid", res_valid, 0);
        check("done", done, m_done);
        check("final_sig", sig, m_sig);
        check("final_err", err_count, m_err);
        check("idle_ready", vec_ready, 1);
    endtask

    logic [40:0] d_a, d_b, d_c;
    logic [40:0] pats [NRND+1];

    initial begin
        rst       = 1'b1;
        vec_valid = 1'b0;
        vec_data  = '0;
        vec_exp   = '0;
        vec_last  = 1'b0;
        res_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset("rst");

        // Zero pattern, matching response, single-pattern session.
        apply(41'd0, 32'd0, 1'b1, 0, 41'd0);
        check("t0_sig", sig, 32'h0);

        // Single-bit response error in a fresh session.
        apply(41'd1, 32'd0, 1'b1, 0, 41'd0);
        check("t1_sig", sig, 32'h1);
        check("t1_err", err_count, 1);

        // Back-pressure with the next pattern offered during the stall.
        d_a = rand_pat();
        d_b = rand_pat();
        apply(d_a, stub_f(d_a), 1'b0, 10, d_b);
        apply(d_b, stub_f(d_b) ^ 32'h80, 1'b1, 0, 41'd0);

        // Reset while settling.
        d_c       = rand_pat();
        vec_data  = d_c;
        vec_exp   = 32'hdead_beef;
        vec_last  = 1'b0;
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset("mid_rst");
        repeat (2) @(negedge clk);
        check("mid_rst_no_res", res_valid, 0);
        apply(d_c, stub_f(d_c), 1'b1, 0, 41'd0);

        // 17 mismatching patterns: counter saturation and index wrap.
        for (int i = 0; i < 17; i++) begin
            d_a = rand_pat();
            apply(d_a, stub_f(d_a) ^ ($urandom() | 32'h1), (i == 16), 0, 41'd0);
            if (i == 15) check("sat_15", err_count, 15);
        end
        check("sat_err", err_count, 15);

        // Random sessions.
        for (int i = 0; i <= NRND; i++) pats[i] = rand_pat();
        for (int i = 0; i < NRND; i++) begin
            bit          lst, bad;
            int          hold;
            logic [31:0] e;
            lst  = ($urandom_range(0, 4) == 0) || (i == NRND - 1);
            bad  = $urandom_range(0, 1) == 1;
            hold = (i == NRND - 1) ? 0 : $urandom_range(0, 3);
            e    = stub_f(pats[i]) ^ (bad ? ($urandom() | 32'h1) : 32'h0);
            apply(pats[i], e, lst, hold, pats[i+1]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
